channel_sum_reduce: RTL and testbench



---
 rtl/channel_sum_reduce_if.sv | 34 +++
 rtl/channel_sum_reduce.sv | 132 +++++++++++++
 tb/tb_channel_sum_reduce.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/channel_sum_reduce_if.sv
// Channel bundle for channel_sum_reduce: input-FIFO and output-FIFO handshake/data signals.
// master = reduction block side, slave = FIFO/environment side.
interface channel_sum_reduce_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_out_data;
  logic             in_read_ready;
  logic             in_write_ready;
  logic             in_read_valid;
  logic [WIDTH-1:0] in_in_data;
  logic             in_write_valid;
  logic             in_rst;
  logic [WIDTH-1:0] out_out_data;
  logic             out_read_ready;
  logic             out_write_ready;
  logic [WIDTH-1:0] out_in_data;
  logic             out_write_valid;
  logic             out_read_valid;
  logic             out_rst;

  modport master (
    input  in_out_data, in_read_ready, in_write_ready,
    input  out_out_data, out_read_ready, out_write_ready,
    output in_read_valid, in_in_data, in_write_valid, in_rst,
    output out_in_data, out_write_valid, out_read_valid, out_rst
  );

  modport slave (
    output in_out_data, in_read_ready, in_write_ready,
    output out_out_data, out_read_ready, out_write_ready,
    input  in_read_valid, in_in_data, in_write_valid, in_rst,
    input  out_in_data, out_write_valid, out_read_valid, out_rst
  );
endinterface

// File: rtl/channel_sum_reduce.sv
// Reads COUNT words from an input channel, accumulates them, writes one sum word, then holds valid.
// Optional macro CHANNEL_SUM_REDUCE_SAT_EN: saturating unsigned accumulator instead of wrap-around.
module channel_sum_reduce #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  channel_sum_reduce_if.master  ch,
  output logic                  valid
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_WAIT_IN  = 3'd1,
    S_READ     = 3'd2,
    S_ACC      = 3'd3,
    S_CHECK    = 3'd4,
    S_WAIT_OUT = 3'd5,
    S_WRITE    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             eq_s;
  logic             rd_q;
  logic             wr_q;
  logic             valid_q;
  logic             unused_s;

`ifdef CHANNEL_SUM_REDUCE_SAT_EN
  logic [WIDTH:0]   add_full_s;

  // Carry out of the widened add means overflow: clamp to all ones.
  always_comb begin
    add_full_s = {1'b0, sum_q} + {1'b0, ch.in_out_data};
    if (add_full_s[WIDTH]) begin
      sum_d = {WIDTH{1'b1}};
    end else begin
      sum_d = add_full_s[WIDTH-1:0];
    end
  end
`else
  assign sum_d = sum_q + ch.in_out_data;
`endif

  assign cnt_d = cnt_q + 16'd1;
  assign eq_s  = (cnt_q == 16'(COUNT));

  // Strobes are registered alongside the state so each equals a decode of state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= 16'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          sum_q   <= {WIDTH{1'b0}};
          cnt_q   <= 16'd0;
          state_q <= S_WAIT_IN;
        end
        S_WAIT_IN: begin
          if (ch.in_read_ready) begin
            state_q <= S_READ;
            rd_q    <= 1'b1;
          end else begin
            state_q <= S_WAIT_IN;
          end
        end
        S_READ: begin
          state_q <= S_ACC;
        end
        S_ACC: begin
          sum_q   <= sum_d;
          cnt_q   <= cnt_d;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (eq_s) begin
            state_q <= S_WAIT_OUT;
          end else begin
            state_q <= S_WAIT_IN;
          end
        end
        S_WAIT_OUT: begin
          if (ch.out_write_ready) begin
            state_q <= S_WRITE;
            wr_q    <= 1'b1;
          end else begin
            state_q <= S_WAIT_OUT;
          end
        end
        S_WRITE: begin
          state_q <= S_DONE;
          valid_q <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_DONE;
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign ch.in_read_valid   = rd_q;
  assign ch.in_in_data      = {WIDTH{1'b0}};
  assign ch.in_write_valid  = 1'b0;
  assign ch.in_rst          = 1'b0;
  assign ch.out_in_data     = sum_q;
  assign ch.out_write_valid = wr_q;
  assign ch.out_read_valid  = 1'b0;
  assign ch.out_rst         = 1'b0;
  assign valid              = valid_q;

  // Channel inputs this block never consumes.
  assign unused_s = ^{ch.in_write_ready, ch.out_out_data, ch.out_read_ready};

endmodule

// File: tb/tb_channel_sum_reduce.sv
// Directed self-checking bench for channel_sum_reduce (WIDTH=32, COUNT=4).
module tb_channel_sum_reduce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid;

  channel_sum_reduce_if #(.WIDTH(32)) ch_if ();

  channel_sum_reduce #(.WIDTH(32), .COUNT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .ch    (ch_if),
    .valid (valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int rd_n;
  int rd_hi_n;
  int rd_cyc [4];
  int wr_n;
  int wr_cyc;
  logic [31:0] wr_data;
  int valid_first;
  int valid_n;
  logic tie_bad = 1'b0;
  logic [31:0] words [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
  endtask

  // Hold rst across one edge, check all outputs are zero, release; cycle 0 begins.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rst_outs"},
          {ch_if.in_read_valid, ch_if.in_write_valid, ch_if.in_rst, ch_if.out_write_valid,
           ch_if.out_read_valid, ch_if.out_rst, valid}, 7'd0);
    check({tag, "_rst_data"}, {ch_if.out_in_data, ch_if.in_in_data}, 64'd0);
    rst = 1'b0;
    cyc = 0; rd_n = 0; rd_hi_n = 0; wr_n = 0; wr_cyc = -1; wr_data = 32'd0;
    valid_first = -1; valid_n = 0;
    for (int i = 0; i < 4; i++) rd_cyc[i] = -1;
  endtask

  // Run n cycles; in_read_ready is low for cycles rd_lo..rd_hi, out_write_ready high from wr_from.
  task automatic run(input int n, input int rd_lo, input int rd_hi, input int wr_from);
    for (int k = 0; k < n; k++) begin
      ch_if.in_read_ready   = !(cyc >= rd_lo && cyc <= rd_hi);
      ch_if.out_write_ready = (cyc >= wr_from);
      @(posedge clk); #1;
      cyc++;
      if (ch_if.in_read_valid) begin
        rd_hi_n++;
        if (rd_n < 4) begin
          rd_cyc[rd_n] = cyc;
          ch_if.in_out_data = words[rd_n];
        end
        rd_n++;
      end
      if (ch_if.out_write_valid) begin
        wr_n++;
        wr_cyc  = cyc;
        wr_data = ch_if.out_in_data;
      end
      if (valid) begin
        valid_n++;
        if (valid_first < 0) valid_first = cyc;
      end
      if (ch_if.in_write_valid || ch_if.in_rst || ch_if.out_read_valid || ch_if.out_rst ||
          ch_if.in_in_data != 32'd0)
        tie_bad = 1'b1;
    end
  endtask

  initial begin
    ch_if.in_out_data     = 32'd0;
    ch_if.in_read_ready   = 1'b1;
    ch_if.in_write_ready  = 1'b0;
    ch_if.out_out_data    = 32'd0;
    ch_if.out_read_ready  = 1'b0;
    ch_if.out_write_ready = 1'b1;

    // Basic run: 1,2,3,4 with both channels ready.
    load(32'd1, 32'd2, 32'd3, 32'd4);
    do_reset("t1");
    check("t1_init_sum", ch_if.out_in_data, 64'd0);
    run(25, -1, -1, 0);
    check("t1_rd_pulses", rd_n, 64'd4);
    check("t1_rd_high_cycles", rd_hi_n, 64'd4);
    check("t1_rd0_cycle", rd_cyc[0], 64'd2);
    check("t1_rd3_cycle", rd_cyc[3], 64'd14);
    check("t1_wr_pulses", wr_n, 64'd1);
    check("t1_wr_cycle", wr_cyc, 64'd18);
    check("t1_wr_data", wr_data, 64'd10);
    check("t1_valid_first", valid_first, 64'd19);
    check("t1_valid_held", valid, 64'd1);

    // Overflow: wraps by default, clamps with saturation enabled.
    load(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    do_reset("t2");
    run(22, -1, -1, 0);
`ifdef CHANNEL_SUM_REDUCE_SAT_EN
    check("t2_wr_data", wr_data, 64'h0000_0000_FFFF_FFFF);
`else
    check("t2_wr_data", wr_data, 64'd0);
`endif
    check("t2_wr_cycle", wr_cyc, 64'd18);

    // Input stall of 5 cycles before the second word.
    load(32'd1, 32'd2, 32'd3, 32'd4);
    do_reset("t3");
    run(30, 5, 9, 0);
    check("t3_rd1_cycle", rd_cyc[1], 64'd11);
    check("t3_rd_pulses", rd_n, 64'd4);
    check("t3_wr_cycle", wr_cyc, 64'd23);
    check("t3_wr_data", wr_data, 64'd10);

    // Output stall until cycle 30.
    load(32'd1, 32'd2, 32'd3, 32'd4);
    do_reset("t4");
    run(35, -1, -1, 30);
    check("t4_wr_pulses", wr_n, 64'd1);
    check("t4_wr_cycle", wr_cyc, 64'd31);
    check("t4_valid_first", valid_first, 64'd32);
    check("t4_wr_data", wr_data, 64'd10);

    // Reset after two words, then a fresh run 5,6,7,8.
    load(32'd1, 32'd2, 32'd3, 32'd4);
    do_reset("t5a");
    run(9, -1, -1, 0);
    check("t5_partial_reads", rd_n, 64'd2);
    check("t5_partial_sum", ch_if.out_in_data, 64'd3);
    load(32'd5, 32'd6, 32'd7, 32'd8);
    do_reset("t5b");
    run(25, -1, -1, 0);
    check("t5_wr_data", wr_data, 64'd26);
    check("t5_wr_cycle", wr_cyc, 64'd18);
    check("t5_rd_pulses", rd_n, 64'd4);

    // 9,9,9,9 then hold valid for 20 cycles; tied outputs stay low.
    load(32'd9, 32'd9, 32'd9, 32'd9);
    do_reset("t6");
    run(38, -1, -1, 0);
    check("t6_wr_data", wr_data, 64'd36);
    check("t6_valid_cycles", valid_n, 64'd20);
    check("t6_valid_end", valid, 64'd1);
    check("t6_wr_pulses", wr_n, 64'd1);
    check("tie_offs_low", tie_bad, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
